// File: rtl/rds_pkg.sv
// rtl/rds_pkg.sv - shared RDS block constants, id encodings and offset helpers
package rds_pkg;

    localparam int          C_BLOCK_W = 26;
    localparam int          C_INFO_W  = 16;
    localparam int          C_CHECK_W = 10;
    localparam logic [10:0] C_POLY    = 11'h5B9;

    localparam logic [9:0] C_OFS_A  = 10'h0FC;
    localparam logic [9:0] C_OFS_B  = 10'h198;
    localparam logic [9:0] C_OFS_C  = 10'h168;
    localparam logic [9:0] C_OFS_CP = 10'h350;
    localparam logic [9:0] C_OFS_D  = 10'h1B4;

    typedef enum logic [2:0] {
        ID_A   = 3'd0,
        ID_B   = 3'd1,
        ID_C   = 3'd2,
        ID_CP  = 3'd3,
        ID_D   = 3'd4,
        ID_BAD = 3'd7
    } block_id_e;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_PRESYNC = 2'd1,
        ST_SYNCED  = 2'd2
    } sync_state_e;

    function automatic block_id_e offset_to_id(input logic [9:0] s);
        case (s)
            C_OFS_A:  return ID_A;
            C_OFS_B:  return ID_B;
            C_OFS_C:  return ID_C;
            C_OFS_CP: return ID_CP;
            C_OFS_D:  return ID_D;
            default:  return ID_BAD;
        endcase
    endfunction

    function automatic block_id_e next_id(input block_id_e id);
        case (id)
            ID_A:        return ID_B;
            ID_B:        return ID_C;
            ID_C, ID_CP: return ID_D;
            default:     return ID_A;
        endcase
    endfunction

    // An expected C slot accepts either C or C'.
    function automatic logic id_matches(input block_id_e want, input block_id_e got);
        if (want == ID_C)
            return (got == ID_C) || (got == ID_CP);
        return got == want;
    endfunction

endpackage

// File: rtl/rds_syndrome.sv
// rtl/rds_syndrome.sv - combinational 26-bit block remainder modulo the RDS generator
module rds_syndrome
    import rds_pkg::*;
(
    input  logic [C_BLOCK_W-1:0] i_word,
    output logic [C_CHECK_W-1:0] o_syndrome
);

    logic [C_CHECK_W:0] w_rem;

    always_comb begin
        w_rem = '0;
        for (int i = C_BLOCK_W - 1; i >= 0; i--) begin
            w_rem = {w_rem[C_CHECK_W-1:0], i_word[i]};
            if (w_rem[C_CHECK_W])
                w_rem = w_rem ^ C_POLY;
        end
    end

    assign o_syndrome = w_rem[C_CHECK_W-1:0];

endmodule

// File: rtl/rds_block_sync.sv
// rtl/rds_block_sync.sv - RDS block boundary search, flywheel sync and group assembly
module rds_block_sync
    import rds_pkg::*;
#(
    parameter int c_sync_blocks = 2,
    parameter int c_loss_blocks = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic [C_INFO_W-1:0] block_data,
    output logic [2:0]          block_id,
    output logic                block_valid,
    output logic                block_ok,
    output logic [63:0]         group_data,
    output logic                group_valid,
    output logic                synced
);

    localparam logic [7:0] C_SYNC_N = 8'(c_sync_blocks);
    localparam logic [7:0] C_LOSS_N = 8'(c_loss_blocks);

    sync_state_e           r_state, w_state_n;
    block_id_e             r_expect, w_expect_n, w_hit, r_block_id, w_block_id_n;
    // Only 25 bits of history are kept; the 26-bit window includes the incoming bit.
    logic [C_BLOCK_W-2:0]  r_sr, w_sr_n;
    logic [C_BLOCK_W-1:0]  w_sr_shift;
    logic [C_CHECK_W-1:0]  w_syn;
    logic [4:0]            r_bitcnt, w_bitcnt_n;
    logic [7:0]            r_goodcnt, w_goodcnt_n, r_badcnt, w_badcnt_n;
    logic [1:0]            r_have, w_have_n;
    logic [47:0]           r_gbuf, w_gbuf_n;
    logic [C_INFO_W-1:0]   r_block_data, w_block_data_n;
    logic [63:0]           r_group_data, w_group_data_n;
    logic                  r_block_valid, w_block_valid_n, r_block_ok, w_block_ok_n;
    logic                  r_group_valid, w_group_valid_n, r_synced, w_synced_n;
    logic                  w_wrap, w_ok, w_emit;

    assign w_sr_shift = {r_sr, bit_in};

    rds_syndrome u_syndrome (
        .i_word     (w_sr_shift),
        .o_syndrome (w_syn)
    );

    assign w_hit  = offset_to_id(w_syn);
    assign w_wrap = bit_valid && (r_bitcnt == 5'(C_BLOCK_W - 1));
    assign w_ok   = id_matches(r_expect, w_hit);

    always_comb begin
        w_state_n       = r_state;
        w_expect_n      = r_expect;
        w_sr_n          = r_sr;
        w_bitcnt_n      = r_bitcnt;
        w_goodcnt_n     = r_goodcnt;
        w_badcnt_n      = r_badcnt;
        w_have_n        = r_have;
        w_gbuf_n        = r_gbuf;
        w_block_data_n  = r_block_data;
        w_block_id_n    = r_block_id;
        w_block_ok_n    = r_block_ok;
        w_group_data_n  = r_group_data;
        w_synced_n      = r_synced;
        w_block_valid_n = 1'b0;
        w_group_valid_n = 1'b0;
        w_emit          = 1'b0;

        if (bit_valid) begin
            w_sr_n     = w_sr_shift[C_BLOCK_W-2:0];
            w_bitcnt_n = w_wrap ? 5'd0 : r_bitcnt + 5'd1;
        end

        case (r_state)
            ST_SEARCH: begin
                if (bit_valid && (w_hit != ID_BAD)) begin
                    w_state_n   = ST_PRESYNC;
                    w_expect_n  = next_id(w_hit);
                    w_bitcnt_n  = 5'd0;
                    w_goodcnt_n = 8'd1;
                end
            end
            ST_PRESYNC: begin
                if (w_wrap) begin
                    w_emit = 1'b1;
                    if (w_ok) begin
                        w_goodcnt_n = r_goodcnt + 8'd1;
                        w_expect_n  = next_id(r_expect);
                        if (r_goodcnt + 8'd1 >= C_SYNC_N) begin
                            w_state_n  = ST_SYNCED;
                            w_synced_n = 1'b1;
                            w_badcnt_n = 8'd0;
                        end
                    end else begin
                        w_state_n = ST_SEARCH;
                    end
                end
            end
            ST_SYNCED: begin
                if (w_wrap) begin
                    w_emit     = 1'b1;
                    w_expect_n = next_id(r_expect);
                    if (w_ok) begin
                        w_badcnt_n = 8'd0;
                    end else if (r_badcnt + 8'd1 >= C_LOSS_N) begin
                        w_state_n  = ST_SEARCH;
                        w_synced_n = 1'b0;
                        w_badcnt_n = 8'd0;
                    end else begin
                        w_badcnt_n = r_badcnt + 8'd1;
                    end
                end
            end
            default: w_state_n = ST_SEARCH;
        endcase

        if (w_emit) begin
            w_block_valid_n = 1'b1;
            w_block_data_n  = w_sr_shift[C_BLOCK_W-1:C_CHECK_W];
            w_block_id_n    = w_ok ? w_hit : ID_BAD;
            w_block_ok_n    = w_ok;
            w_have_n        = 2'd0;
            if (w_ok) begin
                case (w_hit)
                    ID_A: begin
                        w_have_n        = 2'd1;
                        w_gbuf_n[47:32] = w_block_data_n;
                    end
                    ID_B: begin
                        if (r_have == 2'd1) begin
                            w_have_n        = 2'd2;
                            w_gbuf_n[31:16] = w_block_data_n;
                        end
                    end
                    ID_C, ID_CP: begin
                        if (r_have == 2'd2) begin
                            w_have_n       = 2'd3;
                            w_gbuf_n[15:0] = w_block_data_n;
                        end
                    end
                    ID_D: begin
                        if (r_have == 2'd3) begin
                            w_group_valid_n = 1'b1;
                            w_group_data_n  = {r_gbuf, w_block_data_n};
                        end
                    end
                    default: w_have_n = 2'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_SEARCH;
            r_expect      <= ID_A;
            r_sr          <= '0;
            r_bitcnt      <= '0;
            r_goodcnt     <= '0;
            r_badcnt      <= '0;
            r_have        <= '0;
            r_gbuf        <= '0;
            r_block_data  <= '0;
            r_block_id    <= ID_A;
            r_block_ok    <= 1'b0;
            r_block_valid <= 1'b0;
            r_group_data  <= '0;
            r_group_valid <= 1'b0;
            r_synced      <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_expect      <= w_expect_n;
            r_sr          <= w_sr_n;
            r_bitcnt      <= w_bitcnt_n;
            r_goodcnt     <= w_goodcnt_n;
            r_badcnt      <= w_badcnt_n;
            r_have        <= w_have_n;
            r_gbuf        <= w_gbuf_n;
            r_block_data  <= w_block_data_n;
            r_block_id    <= w_block_id_n;
            r_block_ok    <= w_block_ok_n;
            r_block_valid <= w_block_valid_n;
            r_group_data  <= w_group_data_n;
            r_group_valid <= w_group_valid_n;
            r_synced      <= w_synced_n;
        end
    end

    assign block_data  = r_block_data;
    assign block_id    = r_block_id;
    assign block_ok    = r_block_ok;
    assign block_valid = r_block_valid;
    assign group_data  = r_group_data;
    assign group_valid = r_group_valid;
    assign synced      = r_synced;

endmodule

// File: tb/tb_rds_block_sync.sv
// tb/tb_rds_block_sync.sv - scoreboard bench for rds_block_sync
module tb_rds_block_sync;

    localparam logic [9:0]  OFS_A  = 10'h0FC;
    localparam logic [9:0]  OFS_B  = 10'h198;
    localparam logic [9:0]  OFS_C  = 10'h168;
    localparam logic [9:0]  OFS_CP = 10'h350;
    localparam logic [9:0]  OFS_D  = 10'h1B4;
    localparam logic [15:0] PI_W   = 16'h1234;
    localparam logic [15:0] B_W    = 16'h0408;
    localparam logic [15:0] C_W    = 16'hE0CD;
    localparam logic [15:0] D_W    = 16'h5244;
    localparam logic [63:0] GRP    = 64'h12340408E0CD5244;

    logic        clk = 1'b0;
    logic        reset, bit_in, bit_valid;
    logic [15:0] block_data;
    logic [2:0]  block_id;
    logic        block_valid, block_ok, group_valid, synced;
    logic [63:0] group_data;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  id;
        logic        ok;
        logic        grp;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_exp;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   gap_max = 0;

    rds_block_sync dut (
        .clk         (clk),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .block_data  (block_data),
        .block_id    (block_id),
        .block_valid (block_valid),
        .block_ok    (block_ok),
        .group_data  (group_data),
        .group_valid (group_valid),
        .synced      (synced)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #4000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] poly_mod(input logic [25:0] v);
        logic [25:0] r;
        r = v;
        for (int i = 25; i >= 10; i--)
            if (r[i]) r = r ^ (26'h5B9 << (i - 10));
        return r[9:0];
    endfunction

    function automatic logic [25:0] encode(input logic [15:0] m, input logic [9:0] ofs);
        return {m, poly_mod({m, 10'd0}) ^ ofs};
    endfunction

    function automatic bit is_offset(input logic [9:0] s);
        return s inside {OFS_A, OFS_B, OFS_C, OFS_CP, OFS_D};
    endfunction

    always @(negedge clk) begin
        if (block_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got data=%h id=%0d ok=%0d required no pulse", block_data, block_id, block_ok);
            end else begin
                m_exp = sb.pop_front();
                if (cyc != m_exp.cyc) begin
                    errors++;
                    $display("FAIL pulse_latency got cycle %0d required %0d", cyc, m_exp.cyc);
                end
                checks++;
                if (block_data !== m_exp.data) begin
                    errors++;
                    $display("FAIL block_data got %h required %h", block_data, m_exp.data);
                end
                checks++;
                if (block_id !== m_exp.id) begin
                    errors++;
                    $display("FAIL block_id got %0d required %0d", block_id, m_exp.id);
                end
                checks++;
                if (block_ok !== m_exp.ok) begin
                    errors++;
                    $display("FAIL block_ok got %0d required %0d", block_ok, m_exp.ok);
                end
                checks++;
                if (group_valid !== m_exp.grp) begin
                    errors++;
                    $display("FAIL group_valid got %0d required %0d", group_valid, m_exp.grp);
                end
                if (m_exp.grp) begin
                    checks++;
                    if (group_data !== GRP) begin
                        errors++;
                        $display("FAIL group_data got %h required %h", group_data, GRP);
                    end
                end
            end
        end else if (group_valid) begin
            checks++;
            errors++;
            $display("FAIL group_without_block got group_valid=1 required 0");
        end
    end

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        if (gap_max > 0)
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
    endtask

    task automatic send_block(input logic [15:0] m, input logic [9:0] ofs, input logic [25:0] flip,
                              input bit pulse, input logic [2:0] id, input bit ok, input bit grp);
        logic [25:0] cw;
        exp_t e;
        cw = encode(m, ofs) ^ flip;
        for (int i = 25; i >= 1; i--) send_bit(cw[i]);
        if (pulse) begin
            e.data = cw[25:10];
            e.id   = id;
            e.ok   = ok;
            e.grp  = grp;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        send_bit(cw[0]);
    endtask

    task automatic send_group(input bit use_cp, input logic [25:0] flip_b, input bit pulse_a, input bit grp);
        bit b_ok;
        b_ok = (flip_b == 26'd0);
        send_block(PI_W, OFS_A, 26'd0, pulse_a, 3'd0, 1'b1, 1'b0);
        send_block(B_W, OFS_B, flip_b, 1'b1, b_ok ? 3'd1 : 3'd7, b_ok, 1'b0);
        send_block(C_W, use_cp ? OFS_CP : OFS_C, 26'd0, 1'b1, use_cp ? 3'd3 : 3'd2, 1'b1, 1'b0);
        send_block(D_W, OFS_D, 26'd0, 1'b1, 3'd4, 1'b1, grp);
    endtask

    task automatic drain_check(input string name);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got %0d outstanding pulses required 0", name, sb.size());
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({block_valid, block_ok, group_valid, synced} !== 4'b0) begin
            errors++;
            $display("FAIL %s_flags got %b required 0000", name, {block_valid, block_ok, group_valid, synced});
        end
        checks++;
        if (block_id !== 3'd0 || block_data !== 16'd0) begin
            errors++;
            $display("FAIL %s_block got id=%0d data=%h required 0 0000", name, block_id, block_data);
        end
        checks++;
        if (group_data !== 64'd0) begin
            errors++;
            $display("FAIL %s_group_data got %h required 0", name, group_data);
        end
    endtask

    task automatic check_synced(input string name, input logic want);
        checks++;
        if (synced !== want) begin
            errors++;
            $display("FAIL %s got synced=%0d required %0d", name, synced, want);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic test_clean();
        do_reset();
        gap_max = 0;
        send_block(PI_W, OFS_A, 26'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        check_synced("clean_after_block1", 1'b0);
        send_block(B_W, OFS_B, 26'd0, 1'b1, 3'd1, 1'b1, 1'b0);
        check_synced("clean_after_block2", 1'b1);
        send_block(C_W, OFS_C, 26'd0, 1'b1, 3'd2, 1'b1, 1'b0);
        send_block(D_W, OFS_D, 26'd0, 1'b1, 3'd4, 1'b1, 1'b0);
        send_group(1'b0, 26'd0, 1'b1, 1'b1);
        send_group(1'b0, 26'd0, 1'b1, 1'b1);
        drain_check("clean");
    endtask

    task automatic test_phase();
        logic [10:0] pre;
        logic [25:0] a_cw, w;
        bit          clean_pre;
        int          tries;
        a_cw  = encode(PI_W, OFS_A);
        tries = 0;
        do begin
            pre       = 11'($urandom);
            w         = 26'd0;
            clean_pre = 1'b1;
            for (int i = 10; i >= 0; i--) begin
                w = {w[24:0], pre[i]};
                if (is_offset(poly_mod(w))) clean_pre = 1'b0;
            end
            for (int i = 25; i >= 1; i--) begin
                w = {w[24:0], a_cw[i]};
                if (is_offset(poly_mod(w))) clean_pre = 1'b0;
            end
            tries++;
        end while (!clean_pre && tries < 200);
        do_reset();
        gap_max = 2;
        for (int i = 10; i >= 0; i--) send_bit(pre[i]);
        send_group(1'b0, 26'd0, 1'b0, 1'b0);
        check_synced("phase_synced", 1'b1);
        send_group(1'b0, 26'd0, 1'b1, 1'b1);
        send_group(1'b0, 26'd0, 1'b1, 1'b1);
        drain_check("phase");
        gap_max = 0;
    endtask

    task automatic test_cprime();
        send_group(1'b1, 26'd0, 1'b1, 1'b1);
        drain_check("cprime");
    endtask

    task automatic test_bit_error();
        send_group(1'b0, 26'd1 << 20, 1'b1, 1'b0);
        check_synced("biterr_synced", 1'b1);
        checks++;
        if (group_data !== GRP) begin
            errors++;
            $display("FAIL biterr_group_hold got %h required %h", group_data, GRP);
        end
        send_group(1'b0, 26'd0, 1'b1, 1'b1);
        drain_check("biterr");
    endtask

    task automatic test_loss();
        for (int k = 0; k < 8; k++) begin
            send_block(16'd0, 10'd0, 26'd0, 1'b1, 3'd7, 1'b0, 1'b0);
            if (k == 6) check_synced("loss_after7", 1'b1);
        end
        #2;
        check_synced("loss_after8", 1'b0);
        send_block(PI_W, OFS_A, 26'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        check_synced("resync_after_a", 1'b0);
        send_block(B_W, OFS_B, 26'd0, 1'b1, 3'd1, 1'b1, 1'b0);
        check_synced("resync_after_b", 1'b1);
        send_block(C_W, OFS_C, 26'd0, 1'b1, 3'd2, 1'b1, 1'b0);
        send_block(D_W, OFS_D, 26'd0, 1'b1, 3'd4, 1'b1, 1'b0);
        send_group(1'b0, 26'd0, 1'b1, 1'b1);
        drain_check("loss");
    endtask

    task automatic test_reset_mid();
        logic [25:0] c_cw;
        c_cw = encode(C_W, OFS_C);
        send_block(PI_W, OFS_A, 26'd0, 1'b1, 3'd0, 1'b1, 1'b0);
        send_block(B_W, OFS_B, 26'd0, 1'b1, 3'd1, 1'b1, 1'b0);
        for (int i = 25; i >= 13; i--) send_bit(c_cw[i]);
        do_reset();
        check_idle_outputs("reset_mid");
        send_group(1'b0, 26'd0, 1'b0, 1'b0);
        check_synced("reset_mid_resync", 1'b1);
        send_group(1'b0, 26'd0, 1'b1, 1'b1);
        drain_check("reset_mid");
    endtask

    initial begin
        reset     = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        test_reset();
        test_clean();
        test_phase();
        test_cprime();
        test_bit_error();
        test_loss();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
